// File: rtl/fm_mon_pkg.sv
// fm_mon_pkg
// Shared types and helper functions for the bounded-response window monitor.
//   LAT_W          : width of latency values (attempt ages)
//   lat_t          : latency / age type
//   popcount_f     : number of set bits among the low 'len' bits of a vector
//   highest_set_f  : index of the highest set bit among the low 'len' bits
package fm_mon_pkg;

   localparam int LAT_W = 8;

   typedef logic [LAT_W-1:0] lat_t;

   function automatic logic [LAT_W:0] popcount_f(input logic [255:0] vec, input int len);
      logic [LAT_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < 256; i++) begin
         if ((i < len) && vec[i]) cnt = cnt + (LAT_W+1)'(1);
      end
      return cnt;
   endfunction

   // Returns 0 when no bit is set; callers only use the result when the
   // vector is known to be non-zero.
   function automatic lat_t highest_set_f(input logic [255:0] vec, input int len);
      lat_t res;
      res = '0;
      for (int i = 0; i < 256; i++) begin
         if ((i < len) && vec[i]) res = lat_t'(i);
      end
      return res;
   endfunction

endpackage

// File: rtl/fm_window_monitor_sat_counter.sv
// fm_sat_counter
// Saturating accumulator: adds inc_i every clock, clamps at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : increment for this cycle (0 .. 2^(LAT_W+1)-1)
//   cnt_o      : accumulated count, never wraps
module fm_sat_counter
   import fm_mon_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LAT_W:0]   inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   // One bit wider than the widest operand so a large increment onto a
   // nearly-full counter is seen as overflow instead of wrapping.
   localparam int SUM_W = ((CNT_W > LAT_W+1) ? CNT_W : LAT_W+1) + 1;
   localparam logic [SUM_W-1:0] MAX_V = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [CNT_W-1:0] r_cnt;
   logic [SUM_W-1:0] w_sum;

   assign w_sum = {{(SUM_W-CNT_W){1'b0}}, r_cnt} + {{(SUM_W-LAT_W-1){1'b0}}, inc_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_sum > MAX_V) begin
         r_cnt <= '1;
      end else begin
         r_cnt <= w_sum[CNT_W-1:0];
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/fm_window_monitor.sv
// fm_window_monitor
// Hardware checker for  trig |-> first_match(##[MIN_DLY:MAX_DLY] ready)
// (or |=> when NONOVERLAP=1). Every outstanding attempt is one bit of an
// age vector, so overlapping triggers are tracked exactly.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : 1 = accept new triggers; pending attempts always resolve
//   trig_i      : antecedent
//   ready_i     : consequent
//   pass_o      : pulse, >=1 attempt passed at the previous edge
//   fail_o      : pulse, >=1 attempt failed at the previous edge
//   pass_cnt_o  : saturating count of passed attempts
//   fail_cnt_o  : saturating count of failed attempts
//   pending_o   : >=1 attempt unresolved
//   last_lat_o  : age of the oldest attempt passed at the latest pass event
// Optional build macro FM_MONITOR_MAXLAT_EN adds:
//   max_lat_o   : largest last_lat_o seen since reset
//   win_err_o   : sticky, set with the first fail_o pulse
// MIN_DLY <= MAX_DLY and MAX_DLY+NONOVERLAP must fit in LAT_W bits.
module fm_window_monitor
   import fm_mon_pkg::*;
#(
   parameter int MIN_DLY    = 0,
   parameter int MAX_DLY    = 10,
   parameter int NONOVERLAP = 0,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             trig_i,
   input  logic             ready_i,
   output logic             pass_o,
   output logic             fail_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic             pending_o,
   output logic [LAT_W-1:0] last_lat_o
`ifdef FM_MONITOR_MAXLAT_EN
   ,
   output logic [LAT_W-1:0] max_lat_o,
   output logic             win_err_o
`endif
);

   localparam int L    = MAX_DLY + NONOVERLAP;
   localparam int LMIN = MIN_DLY + NONOVERLAP;

   logic [L:0]     r_pend;
   logic           r_pass;
   logic           r_fail;
   lat_t           r_last_lat;

   logic [L:0]     w_v;
   logic [L:0]     w_win;
   logic [L:0]     w_p;
   logic           w_f;
   logic [L:0]     w_pend_nxt;
   logic [LAT_W:0] w_pass_inc;
   logic [LAT_W:0] w_fail_inc;
   lat_t           w_hi;

   // Age vector advanced by one edge; the new attempt enters at age 0.
   always_comb begin
      w_v    = '0;
      w_v[0] = trig_i & en_i;
      for (int i = 1; i <= L; i++) begin
         w_v[i] = r_pend[i-1];
      end
   end

   always_comb begin
      w_win = '0;
      for (int i = 0; i <= L; i++) begin
         w_win[i] = (i >= LMIN);
      end
   end

   // All in-window attempts pass together on one ready; only the oldest
   // (age L) can time out.
   assign w_p = w_v & w_win & {(L+1){ready_i}};
   assign w_f = w_v[L] & ~ready_i;

   always_comb begin
      w_pend_nxt    = w_v & ~w_p;
      w_pend_nxt[L] = 1'b0;
   end

   assign w_pass_inc = popcount_f(256'(w_p), L+1);
   assign w_fail_inc = {{LAT_W{1'b0}}, w_f};
   assign w_hi       = highest_set_f(256'(w_p), L+1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= '0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_last_lat <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_pass <= |w_p;
         r_fail <= w_f;
         if (|w_p) r_last_lat <= w_hi;
      end
   end

   fm_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (w_pass_inc),
      .cnt_o (pass_cnt_o)
   );

   fm_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (w_fail_inc),
      .cnt_o (fail_cnt_o)
   );

   assign pass_o     = r_pass;
   assign fail_o     = r_fail;
   assign pending_o  = |r_pend;
   assign last_lat_o = r_last_lat;

`ifdef FM_MONITOR_MAXLAT_EN
   lat_t r_max_lat;
   logic r_win_err;

   // Compared against the value last_lat_o is about to take, so both
   // registers move on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max_lat <= '0;
         r_win_err <= 1'b0;
      end else begin
         if ((|w_p) && (w_hi > r_max_lat)) r_max_lat <= w_hi;
         if (w_f) r_win_err <= 1'b1;
      end
   end

   assign max_lat_o = r_max_lat;
   assign win_err_o = r_win_err;
`else
   // Build without latency high-water mark or sticky window error.
`endif

endmodule

// File: tb/tb_fm_window_monitor.sv
module tb_fm_window_monitor;

   logic clk;
   logic rst_n;

   // u0: defaults
   logic a_en, a_trig, a_rdy, a_pass, a_fail, a_pend;
   logic [15:0] a_pcnt, a_fcnt;
   logic [7:0]  a_lat;
   // u4: MIN_DLY=5, MAX_DLY=5
   logic b_en, b_trig, b_rdy, b_pass, b_fail, b_pend;
   logic [15:0] b_pcnt, b_fcnt;
   logic [7:0]  b_lat;
   // u5: NONOVERLAP=1
   logic c_en, c_trig, c_rdy, c_pass, c_fail, c_pend;
   logic [15:0] c_pcnt, c_fcnt;
   logic [7:0]  c_lat;
   // u6: CNT_W=2
   logic d_en, d_trig, d_rdy, d_pass, d_fail, d_pend;
   logic [1:0]  d_pcnt, d_fcnt;
   logic [7:0]  d_lat;

   int checks = 0;
   int errors = 0;

   fm_window_monitor u0 (
      .clk(clk), .rst_n(rst_n), .en_i(a_en), .trig_i(a_trig), .ready_i(a_rdy),
      .pass_o(a_pass), .fail_o(a_fail), .pass_cnt_o(a_pcnt), .fail_cnt_o(a_fcnt),
      .pending_o(a_pend), .last_lat_o(a_lat)
   );

   fm_window_monitor #(.MIN_DLY(5), .MAX_DLY(5)) u4 (
      .clk(clk), .rst_n(rst_n), .en_i(b_en), .trig_i(b_trig), .ready_i(b_rdy),
      .pass_o(b_pass), .fail_o(b_fail), .pass_cnt_o(b_pcnt), .fail_cnt_o(b_fcnt),
      .pending_o(b_pend), .last_lat_o(b_lat)
   );

   fm_window_monitor #(.MIN_DLY(0), .NONOVERLAP(1)) u5 (
      .clk(clk), .rst_n(rst_n), .en_i(c_en), .trig_i(c_trig), .ready_i(c_rdy),
      .pass_o(c_pass), .fail_o(c_fail), .pass_cnt_o(c_pcnt), .fail_cnt_o(c_fcnt),
      .pending_o(c_pend), .last_lat_o(c_lat)
   );

   fm_window_monitor #(.CNT_W(2)) u6 (
      .clk(clk), .rst_n(rst_n), .en_i(d_en), .trig_i(d_trig), .ready_i(d_rdy),
      .pass_o(d_pass), .fail_o(d_fail), .pass_cnt_o(d_pcnt), .fail_cnt_o(d_fcnt),
      .pending_o(d_pend), .last_lat_o(d_lat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one active edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_en = 1'b1; a_trig = 1'b0; a_rdy = 1'b0;
      b_en = 1'b1; b_trig = 1'b0; b_rdy = 1'b0;
      c_en = 1'b1; c_trig = 1'b0; c_rdy = 1'b0;
      d_en = 1'b1; d_trig = 1'b0; d_rdy = 1'b0;
      #12;
      checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b exp 0", a_pass); end
      checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %0b exp 0", a_fail); end
      checks++; if (a_pcnt !== 16'd0 || a_fcnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", a_pcnt, a_fcnt); end
      checks++; if (a_pend !== 1'b0 || a_lat !== 8'd0) begin errors++; $display("FAIL reset_pend_lat got %0b/%0d exp 0/0", a_pend, a_lat); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_pass();
      a_trig = 1'b1; step();                       // edge 1
      a_trig = 1'b0;
      checks++; if (a_pend !== 1'b1 || a_pass !== 1'b0) begin errors++; $display("FAIL single_e1 pend/pass got %0b/%0b exp 1/0", a_pend, a_pass); end
      step(); step();                              // edges 2,3
      a_rdy = 1'b1; step();                        // edge 4
      checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL single_pass got %0b exp 1", a_pass); end
      checks++; if (a_lat !== 8'd3) begin errors++; $display("FAIL single_lat got %0d exp 3", a_lat); end
      checks++; if (a_pcnt !== 16'd1 || a_fcnt !== 16'd0) begin errors++; $display("FAIL single_cnt got %0d/%0d exp 1/0", a_pcnt, a_fcnt); end
      a_rdy = 1'b0; step();
      checks++; if (a_pass !== 1'b0 || a_pend !== 1'b0) begin errors++; $display("FAIL single_after pass/pend got %0b/%0b exp 0/0", a_pass, a_pend); end
   endtask

   task automatic test_timeout_fail();
      a_trig = 1'b1; step();                       // edge 1
      a_trig = 1'b0;
      for (int i = 2; i <= 10; i++) step();        // edges 2..10
      checks++; if (a_fail !== 1'b0 || a_pend !== 1'b1) begin errors++; $display("FAIL timeout_e10 fail/pend got %0b/%0b exp 0/1", a_fail, a_pend); end
      step();                                      // edge 11, age 10
      checks++; if (a_fail !== 1'b1) begin errors++; $display("FAIL timeout_fail got %0b exp 1", a_fail); end
      checks++; if (a_fcnt !== 16'd1) begin errors++; $display("FAIL timeout_fcnt got %0d exp 1", a_fcnt); end
      checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL timeout_pend got %0b exp 0", a_pend); end
      step();
      checks++; if (a_fail !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %0b exp 0", a_fail); end
   endtask

   task automatic test_overlap();
      a_trig = 1'b1; step(); step(); step();       // edges 1..3
      a_trig = 1'b0; step();                       // edge 4
      a_rdy = 1'b1; step();                        // edge 5: ages 4,3,2
      checks++; if (a_pass !== 1'b1) begin errors++; $display("FAIL overlap_pass got %0b exp 1", a_pass); end
      checks++; if (a_pcnt !== 16'd4) begin errors++; $display("FAIL overlap_pcnt got %0d exp 4", a_pcnt); end
      checks++; if (a_lat !== 8'd4) begin errors++; $display("FAIL overlap_lat got %0d exp 4", a_lat); end
      checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL overlap_pend got %0b exp 0", a_pend); end
      a_rdy = 1'b0; step();
      checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL overlap_single_pulse got %0b exp 0", a_pass); end
   endtask

   task automatic test_enable();
      a_trig = 1'b1; step();                       // edge 1, accepted
      a_en = 1'b0; step();                         // edge 2, ignored
      a_rdy = 1'b1; step();                        // edge 3, age 2 passes
      checks++; if (a_pcnt !== 16'd5 || a_lat !== 8'd2) begin errors++; $display("FAIL enable_pass cnt/lat got %0d/%0d exp 5/2", a_pcnt, a_lat); end
      a_rdy = 1'b0; step();
      checks++; if (a_pend !== 1'b0) begin errors++; $display("FAIL enable_ignored_pend got %0b exp 0", a_pend); end
      a_trig = 1'b0; a_en = 1'b1;
   endtask

   task automatic test_window_min();
      b_trig = 1'b1; step();                       // edge 1
      b_trig = 1'b0; step(); step();               // edges 2,3
      b_rdy = 1'b1; step();                        // edge 4, age 3 too early
      checks++; if (b_pass !== 1'b0 || b_pend !== 1'b1) begin errors++; $display("FAIL minwin_early pass/pend got %0b/%0b exp 0/1", b_pass, b_pend); end
      b_rdy = 1'b0; step(); step();                // edges 5,6
      checks++; if (b_fail !== 1'b1) begin errors++; $display("FAIL minwin_fail got %0b exp 1", b_fail); end
      checks++; if (b_fcnt !== 16'd1 || b_pcnt !== 16'd0) begin errors++; $display("FAIL minwin_cnt f/p got %0d/%0d exp 1/0", b_fcnt, b_pcnt); end
      step();
   endtask

   task automatic test_nonoverlap();
      c_trig = 1'b1; c_rdy = 1'b1; step();         // edge 1, age 0 outside window
      checks++; if (c_pass !== 1'b0 || c_pend !== 1'b1) begin errors++; $display("FAIL nonov_e1 pass/pend got %0b/%0b exp 0/1", c_pass, c_pend); end
      c_trig = 1'b0; c_rdy = 1'b0; step();         // edge 2
      c_rdy = 1'b1; step();                        // edge 3, age 2
      checks++; if (c_pass !== 1'b1 || c_lat !== 8'd2) begin errors++; $display("FAIL nonov_pass pass/lat got %0b/%0d exp 1/2", c_pass, c_lat); end
      checks++; if (c_pcnt !== 16'd1 || c_pend !== 1'b0) begin errors++; $display("FAIL nonov_cnt cnt/pend got %0d/%0b exp 1/0", c_pcnt, c_pend); end
      c_rdy = 1'b0; step();
   endtask

   task automatic test_saturation_reset();
      logic seen_fail;
      d_trig = 1'b1; step(); step(); step(); step(); // edges 1..4
      d_trig = 1'b0; d_rdy = 1'b1; step();           // edge 5: four pass at once
      checks++; if (d_pcnt !== 2'd3 || d_lat !== 8'd4) begin errors++; $display("FAIL sat_pass cnt/lat got %0d/%0d exp 3/4", d_pcnt, d_lat); end
      d_rdy = 1'b0; step();
      d_trig = 1'b1;
      for (int i = 1; i <= 5; i++) step();           // edges 1..5
      d_trig = 1'b0;
      for (int i = 6; i <= 10; i++) step();
      step();                                        // edge 11, first fail
      checks++; if (d_fail !== 1'b1 || d_fcnt !== 2'd1) begin errors++; $display("FAIL sat_first fail/cnt got %0b/%0d exp 1/1", d_fail, d_fcnt); end
      for (int i = 12; i <= 15; i++) step();
      checks++; if (d_fcnt !== 2'd3 || d_fail !== 1'b1) begin errors++; $display("FAIL sat_fcnt cnt/fail got %0d/%0b exp 3/1", d_fcnt, d_fail); end
      step();
      checks++; if (d_fcnt !== 2'd3 || d_pend !== 1'b0) begin errors++; $display("FAIL sat_hold cnt/pend got %0d/%0b exp 3/0", d_fcnt, d_pend); end
      d_trig = 1'b1; step();
      d_trig = 1'b0; step(); step();
      checks++; if (d_pend !== 1'b1) begin errors++; $display("FAIL rst_pre_pend got %0b exp 1", d_pend); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (d_pend !== 1'b0 || d_pass !== 1'b0 || d_fail !== 1'b0) begin errors++; $display("FAIL rst_async pend/pass/fail got %0b/%0b/%0b exp 0/0/0", d_pend, d_pass, d_fail); end
      checks++; if (d_pcnt !== 2'd0 || d_fcnt !== 2'd0 || d_lat !== 8'd0) begin errors++; $display("FAIL rst_async cnt p/f/lat got %0d/%0d/%0d exp 0/0/0", d_pcnt, d_fcnt, d_lat); end
      @(negedge clk);
      rst_n = 1'b1;
      seen_fail = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step();
         seen_fail = seen_fail | d_fail;
      end
      checks++; if (seen_fail !== 1'b0 || d_fcnt !== 2'd0) begin errors++; $display("FAIL rst_silent fail/cnt got %0b/%0d exp 0/0", seen_fail, d_fcnt); end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_timeout_fail();
      test_overlap();
      test_enable();
      test_window_min();
      test_nonoverlap();
      test_saturation_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
